// File: rtl/eau_tx.sv
// eau_tx: serialises one NBYTES-wide word onto an 8-bit valid/ready bus; optional EAU_TX_REPEAT_EN adds rep.
// Latency: first byte valid 1 cycle after ld; one byte per cycle while ready=1; done pulses after the final byte.
// Backpressure: ready=0 holds q/last/index indefinitely; ld (and rep) are ignored while busy.
module eau_tx #(
    parameter int NBYTES    = 2,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [8*NBYTES-1:0]   d,
    input  logic                  ld,
`ifdef EAU_TX_REPEAT_EN
    input  logic                  rep,
`endif
    output logic [7:0]            q,
    output logic                  valid,
    input  logic                  ready,
    output logic                  last,
    output logic                  busy,
    output logic                  done
);

    localparam int                  IW      = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0]       LASTIDX = IW'(NBYTES - 1);
    localparam logic [IW-1:0]       IDX_ONE = IW'(1);
    localparam logic [8*NBYTES-1:0] WORD_ONE = (8*NBYTES)'(1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]          state;
    logic [8*NBYTES-1:0] word;
    logic [IW-1:0]       idx;
    logic [IW-1:0]       sel;
    logic                start;
    logic [8*NBYTES-1:0] next_word;

    always_comb begin
        start     = 1'b0;
        next_word = d;
        if (state == IDLE) begin
            if (ld) begin
                start = 1'b1;
`ifdef EAU_TX_REPEAT_EN
            end else if (rep) begin
                // the word register keeps the last word sent, so repeat is just +1
                start     = 1'b1;
                next_word = word + WORD_ONE;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            word  <= '0;
            idx   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SEND;
                        word  <= next_word;
                        idx   <= '0;
                    end
                end
                SEND: begin
                    if (ready) begin
                        if (idx == LASTIDX) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end else begin
                            idx <= idx + IDX_ONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign sel = MSB_FIRST ? (LASTIDX - idx) : idx;

    // idx is left on the final byte after a word, so q keeps its last value in IDLE
    always_comb begin
        q = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            if (sel == IW'(i)) q = word[8*i +: 8];
        end
    end

    assign valid = (state == SEND);
    assign busy  = (state == SEND);
    assign last  = valid && (idx == LASTIDX);

endmodule

// File: tb/tb_eau_tx.sv
// Bench for eau_tx: two instances (LSB-first and MSB-first) share stimulus; a byte-queue model checks every cycle.
module tb_eau_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] d = 16'h0000;
    logic        ld = 1'b0;
    logic        rep = 1'b0;
    logic        ready = 1'b1;

    logic [7:0]  lq, mq;
    logic        lvalid, mvalid, llast, mlast, lbusy, mbusy, ldone, mdone;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    eau_tx #(.NBYTES(2), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .d(d), .ld(ld),
`ifdef EAU_TX_REPEAT_EN
        .rep(rep),
`endif
        .q(lq), .valid(lvalid), .ready(ready), .last(llast), .busy(lbusy), .done(ldone)
    );

    eau_tx #(.NBYTES(2), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .d(d), .ld(ld),
`ifdef EAU_TX_REPEAT_EN
        .rep(rep),
`endif
        .q(mq), .valid(mvalid), .ready(ready), .last(mlast), .busy(mbusy), .done(mdone)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a word becomes a queue of bytes in wire order; a transfer pops one byte.
    logic [7:0]  lexp[$];
    logic [7:0]  mexp[$];
    logic [7:0]  lhold = 8'h00, mhold = 8'h00;
    logic [15:0] m_prev = 16'h0000;
    bit          m_done = 1'b0;
    bit          rep_on = 1'b0;

    task automatic push_word(input logic [15:0] w);
        m_prev = w;
        lexp.push_back(w[7:0]);
        lexp.push_back(w[15:8]);
        mexp.push_back(w[15:8]);
        mexp.push_back(w[7:0]);
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            lexp.delete();
            mexp.delete();
            lhold  = 8'h00;
            mhold  = 8'h00;
            m_prev = 16'h0000;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (lexp.size() > 0) begin
                if (ready) begin
                    lhold = lexp.pop_front();
                    mhold = mexp.pop_front();
                    if (lexp.size() == 0) m_done = 1'b1;
                end
            end else if (ld) begin
                push_word(d);
            end else if (rep_on && rep) begin
                push_word(m_prev + 16'h0001);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic ev;
            ev = (lexp.size() > 0);
            chk("lsb_valid", {31'd0, lvalid}, {31'd0, ev});
            chk("lsb_busy",  {31'd0, lbusy},  {31'd0, ev});
            chk("lsb_last",  {31'd0, llast},  {31'd0, ev && lexp.size() == 1});
            chk("lsb_done",  {31'd0, ldone},  {31'd0, m_done});
            chk("lsb_q",     {24'd0, lq},     {24'd0, ev ? lexp[0] : lhold});
            chk("msb_valid", {31'd0, mvalid}, {31'd0, ev});
            chk("msb_last",  {31'd0, mlast},  {31'd0, ev && mexp.size() == 1});
            chk("msb_done",  {31'd0, mdone},  {31'd0, m_done});
            chk("msb_q",     {24'd0, mq},     {24'd0, ev ? mexp[0] : mhold});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef EAU_TX_REPEAT_EN
        rep_on = 1'b1;
`endif
        // reset for two edges
        rst = 1'b0;
        tick();
        tick();
        chk_en = 1'b1;
        chk("rst_q", {24'd0, lq}, 32'h00);
        chk("rst_valid", {31'd0, lvalid}, 32'd0);
        chk("rst_last", {31'd0, llast}, 32'd0);
        chk("rst_busy", {31'd0, lbusy}, 32'd0);
        chk("rst_done", {31'd0, ldone}, 32'd0);

        // basic word
        rst = 1'b1; ready = 1'b1; ld = 1'b1; d = 16'h4064;
        tick();
        ld = 1'b0;
        chk("b0_q", {24'd0, lq}, 32'h64);
        chk("b0_valid", {31'd0, lvalid}, 32'd1);
        chk("b0_last", {31'd0, llast}, 32'd0);
        chk("b0_msb_q", {24'd0, mq}, 32'h40);
        tick();
        chk("b1_q", {24'd0, lq}, 32'h40);
        chk("b1_last", {31'd0, llast}, 32'd1);
        tick();
        chk("b_done", {31'd0, ldone}, 32'd1);
        chk("b_done_valid", {31'd0, lvalid}, 32'd0);
        chk("b_hold_q", {24'd0, lq}, 32'h40);
        tick();
        chk("b_done_gone", {31'd0, ldone}, 32'd0);

        // back-pressure: three stalled cycles on the first byte
        ld = 1'b1; d = 16'h4064; ready = 1'b0;
        tick();
        ld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold_q", {24'd0, lq}, 32'h64);
            tick();
        end
        ready = 1'b1;
        chk("bp_rel_q", {24'd0, lq}, 32'h64);
        tick();
        chk("bp_next_q", {24'd0, lq}, 32'h40);
        tick();
        tick();

        // MSB first ordering
        ld = 1'b1; d = 16'h2010;
        tick();
        ld = 1'b0;
        chk("msb_b0", {24'd0, mq}, 32'h20);
        tick();
        chk("msb_b1", {24'd0, mq}, 32'h10);
        tick();
        chk("msb_done", {31'd0, mdone}, 32'd1);
        tick();
        chk("msb_done_once", {31'd0, mdone}, 32'd0);

        // ld ignored while busy, including on the final-transfer edge
        ld = 1'b1; d = 16'h4064;
        tick();
        d = 16'hBEEF;
        chk("ign_b0", {24'd0, lq}, 32'h64);
        tick();
        chk("ign_b1", {24'd0, lq}, 32'h40);
        tick();
        ld = 1'b0;
        chk("ign_idle", {31'd0, lvalid}, 32'd0);
        chk("ign_done", {31'd0, ldone}, 32'd1);
        tick();

        // mid-word reset aborts the word
        ld = 1'b1; d = 16'h1234;
        tick();
        ld = 1'b0;
        chk("mr_b0", {24'd0, lq}, 32'h34);
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("mr_valid", {31'd0, lvalid}, 32'd0);
        chk("mr_busy", {31'd0, lbusy}, 32'd0);
        tick();
        tick();
        chk("mr_no_resume", {31'd0, lvalid}, 32'd0);

        // back-to-back words with a load in the done cycle
        ld = 1'b1; d = 16'hA55A;
        tick();
        ld = 1'b0;
        tick();
        tick();
        ld = 1'b1; d = 16'h0102;
        chk("bb_bubble", {31'd0, lvalid}, 32'd0);
        tick();
        ld = 1'b0;
        chk("bb_b0", {24'd0, lq}, 32'h02);
        tick();
        tick();

        // reset wins over ld on the same edge
        rst = 1'b0; ld = 1'b1; d = 16'h7777;
        tick();
        rst = 1'b1; ld = 1'b0;
        chk("rl_valid", {31'd0, lvalid}, 32'd0);
        tick();

        // irregular ready pattern over a few words
        for (int w = 0; w < 6; w++) begin
            ld = 1'b1; d = 16'(16'h1357 * (w + 1));
            ready = w[0];
            tick();
            ld = 1'b0;
            for (int c = 0; c < 8; c++) begin
                ready = ((c + w) % 3) != 0;
                tick();
            end
        end
        ready = 1'b1;
        tick();
        tick();

`ifdef EAU_TX_REPEAT_EN
        ld = 1'b1; d = 16'hFFFF;
        tick();
        ld = 1'b0;
        tick();
        tick();
        rep = 1'b1;
        tick();
        rep = 1'b0;
        chk("rep_b0", {24'd0, lq}, 32'h00);
        tick();
        chk("rep_b1", {24'd0, lq}, 32'h00);
        tick();
        rep = 1'b1;
        tick();
        rep = 1'b0;
        chk("rep2_b0", {24'd0, lq}, 32'h01);
        tick();
        chk("rep2_b1", {24'd0, lq}, 32'h00);
        tick();
        rep = 1'b1; ld = 1'b1; d = 16'h5566;
        tick();
        rep = 1'b0; ld = 1'b0;
        chk("rep_ld_wins", {24'd0, lq}, 32'h66);
        tick();
        tick();
`endif

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
